spi_master_tx: RTL
==================

Name: spi_master_tx

Overview:
- SPI master transmit shifter; serialises 32-bit words from the TX FIFO onto sdo0 (standard) or sdo3..sdo0 (quad).
- Sits beside the SPI master receive shifter, under the SPI master controller.
- Shares tx_edge timing from the clock generator and gates that generator through clk_en_o.
- Bit count per transfer is programmed by the controller; data is sent MSB-first.

Parameters:
TRGT_RST, 16'h8, reset value of the transfer length target (in shift edges)

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
en  in  1  start request from controller; sampled in IDLE only
tx_edge  in  1  one-cycle strobe from the SPI clock generator: shift point
tx_done  out  1  high for the cycle in which the last edge of the transfer is consumed
sdo0  out  1  serial data 0 (MOSI in standard mode)
sdo1  out  1  serial data 1 (quad only)
sdo2  out  1  serial data 2 (quad only)
sdo3  out  1  serial data 3 (quad only)
en_quad_in  in  1  1 = quad mode (4 bits/edge), 0 = standard mode (1 bit/edge)
counter_in  in  16  transfer length in bits
counter_in_upd  in  1  load strobe for counter_in
data  in  32  TX FIFO word
data_valid  in  1  TX FIFO word available
data_ready  out  1  pop strobe to TX FIFO (combinational)
clk_en_o  out  1  enable for the SPI clock generator (combinational)

Behaviour:
- Reset values: counter=0, counter_trgt=TRGT_RST, data_int=0, state=IDLE. Outputs at reset: sdo*=0, tx_done=0, data_ready=0, clk_en_o=0.
- Target update: on counter_in_upd, counter_trgt <= en_quad ? counter_in>>2 : counter_in. It takes effect the next cycle, including mid-transfer.
- counter_in=0 is illegal. The compare target wraps to 16'hFFFF, which yields 65536 edges.
- Output mapping (combinational from data_int):
  - Standard mode: sdo0=data_int[31]; sdo1..3=0.
  - Quad mode: {sdo3,sdo2,sdo1,sdo0}=data_int[31:28].
- word_end = (!en_quad && counter[4:0]==31) || (en_quad && counter[2:0]==7).
- tx_done = (state==TRANSMIT) && tx_edge && (counter==counter_trgt-1), using 16-bit modular arithmetic.
- State IDLE; clk_en_o=0.
  - If en && data_valid: data_ready=1, data_int<=data, counter<=0, go to TRANSMIT.
  - If en && !data_valid: go to WAIT_FIFO.
- State TRANSMIT; clk_en_o=1.
  - On tx_edge: counter+=1; data_int shifts left by 1 (standard) or 4 (quad), zero-filling.
  - If tx_done: counter<=0, go to IDLE, no FIFO pop. tx_done has priority over word_end when both are true.
  - Else if word_end && data_valid: data_ready=1 and data_int<=data, overriding the shift. State stays TRANSMIT with no bubble.
  - Else if word_end && !data_valid: clk_en_o=0 in that same cycle, go to WAIT_FIFO. The counter still increments.
  - With no tx_edge: hold all registers.
- State WAIT_FIFO; clk_en_o=0, outputs hold the last shifted data_int.
  - On data_valid: data_ready=1, data_int<=data, go to TRANSMIT. counter is unchanged.
- en is ignored outside IDLE; deasserting it mid-transfer does not abort.
- tx_edge is ignored in IDLE and WAIT_FIFO.
- data_ready is high in at most one cycle per accepted word and is never asserted without data_valid.
- Asynchronous reset mid-transfer returns everything to reset values immediately. A partially sent word is discarded; the FIFO is not re-read.
- A transfer length that is not a multiple of 32 (standard) or 8 (quad) edges sends the upper bits of the final word only. The remaining bits are dropped.

Test Plan:
- Standard 32-bit transfer:
  - Stimulus: counter_in=32 with upd; FIFO word 0xA5C3_0F81; en; tx_edge every 4 cycles.
  - Response: sdo0 sequence 1,0,1,0,0,1,0,1,... matches 0xA5C30F81 MSB-first; data_ready pulses once; tx_done on the 32nd edge; state returns to IDLE.
- Quad 64-bit transfer:
  - Stimulus: en_quad=1, counter_in=64 (target 16); words 0x1234_5678 then 0x9ABC_DEF0, both valid up front.
  - Response: nibbles 1..8 then 9..0 on sdo3..0; second pop coincides with the 8th edge; no clk_en_o gap; tx_done on edge 16.
- FIFO underrun:
  - Stimulus: counter_in=64, standard mode; second word delayed 20 cycles.
  - Response: clk_en_o drops in the 32nd-edge cycle; WAIT_FIFO is held; edges arriving meanwhile are ignored; transmission resumes with the new word's MSB when data_valid rises.
- Short transfer:
  - Stimulus: counter_in=8, word 0xF000_00FF.
  - Response: sdo0=1,1,1,1,0,0,0,0; tx_done on the 8th edge; only 1 pop.
- en without data:
  - Stimulus: en with data_valid=0 for 10 cycles, then valid.
  - Response: clk_en_o=0 and data_ready=0 throughout the wait; the first edge after valid shifts data[31].
- Reset mid-word:
  - Stimulus: rstn low after 5 edges.
  - Response: immediately all outputs=0 and counter_trgt=8; after release the block is in IDLE awaiting en.

Source files
------------

// File: rtl/spi_master_tx.sv
// -----------------------------------------------------------------------------
// spi_master_tx
//   SPI master transmit shifter. Pulls 32-bit words from the TX FIFO and
//   serialises them MSB-first. In standard mode one bit goes out on sdo0 per
//   shift edge. In quad mode four bits go out on sdo3..sdo0 per shift edge.
//   The controller programs the transfer length. This block gates the SPI
//   clock generator through clk_en_o whenever it has no data to shift.
//
// Ports
//   clk, rstn        system clock, asynchronous active-low reset
//   en               start request (sampled in IDLE only)
//   tx_edge          one-cycle shift strobe from the SPI clock generator
//   tx_done          high in the cycle that consumes the final shift edge
//   sdo0..sdo3       serial data outputs (sdo1..3 used in quad mode only)
//   en_quad_in       1 = quad (4 bits/edge), 0 = standard (1 bit/edge)
//   counter_in       transfer length in bits
//   counter_in_upd   load strobe for counter_in
//   data, data_valid TX FIFO word and its valid flag
//   data_ready       FIFO pop strobe (combinational)
//   clk_en_o         SPI clock generator enable (combinational)
// -----------------------------------------------------------------------------
module spi_master_tx #(
  parameter logic [15:0] TRGT_RST = 16'h8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  input  logic        tx_edge,
  output logic        tx_done,
  output logic        sdo0,
  output logic        sdo1,
  output logic        sdo2,
  output logic        sdo3,
  input  logic        en_quad_in,
  input  logic [15:0] counter_in,
  input  logic        counter_in_upd,
  input  logic [31:0] data,
  input  logic        data_valid,
  output logic        data_ready,
  output logic        clk_en_o
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TRANSMIT  = 2'd1,
    WAIT_FIFO = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] counter;
  logic [15:0] counter_trgt;
  logic [15:0] trgt_last;
  logic [31:0] data_int;
  logic        word_end;
  logic        load_word;
  logic        shift_en;
  logic        clr_cnt;

  // The target is stored in shift edges. A target of 0 wraps trgt_last to
  // 16'hFFFF, so that transfer runs for 65536 edges.
  assign trgt_last = counter_trgt - 16'd1;

  // The current edge shifts out the last bit/nibble of the word in data_int.
  assign word_end = en_quad_in ? (counter[2:0] == 3'd7) : (counter[4:0] == 5'd31);

  assign tx_done = (state == TRANSMIT) && tx_edge && (counter == trgt_last);

  // Serial outputs come straight from the top of the shift register.
  assign sdo0 = en_quad_in ? data_int[28] : data_int[31];
  assign sdo1 = en_quad_in & data_int[29];
  assign sdo2 = en_quad_in & data_int[30];
  assign sdo3 = en_quad_in & data_int[31];

  // State register
  // NOTE: sequential state uses non-blocking (<=) assignments only. All
  // registers then update together from values sampled before the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  // NOTE: every output of a combinational block gets a default first. A path
  // that leaves a signal unassigned would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (en) state_next = data_valid ? TRANSMIT : WAIT_FIFO;
      end
      TRANSMIT: begin
        if (tx_done)                       state_next = IDLE;
        else if (tx_edge && word_end && !data_valid) state_next = WAIT_FIFO;
      end
      WAIT_FIFO: begin
        if (data_valid) state_next = TRANSMIT;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output / datapath-control logic
  always_comb begin
    data_ready = 1'b0;
    clk_en_o   = 1'b0;
    load_word  = 1'b0;
    shift_en   = 1'b0;
    clr_cnt    = 1'b0;
    unique case (state)
      IDLE: begin
        if (en && data_valid) begin
          data_ready = 1'b1;
          load_word  = 1'b1;
          clr_cnt    = 1'b1;
        end
      end
      TRANSMIT: begin
        clk_en_o = 1'b1;
        if (tx_edge) begin
          shift_en = 1'b1;
          // tx_done wins over word_end: the last edge never pops the FIFO.
          if (tx_done) begin
            clr_cnt = 1'b1;
          end else if (word_end && data_valid) begin
            data_ready = 1'b1;
            load_word  = 1'b1;
          end else if (word_end) begin
            // Underrun: stop the SPI clock in the same cycle.
            clk_en_o = 1'b0;
          end
        end
      end
      WAIT_FIFO: begin
        if (data_valid) begin
          data_ready = 1'b1;
          load_word  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Edge counter and shift register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      counter  <= 16'd0;
      data_int <= 32'd0;
    end else begin
      if (clr_cnt)       counter <= 16'd0;
      else if (shift_en) counter <= counter + 16'd1;

      // A freshly loaded word replaces the shift result.
      if (load_word)     data_int <= data;
      else if (shift_en) data_int <= en_quad_in ? {data_int[27:0], 4'd0}
                                                : {data_int[30:0], 1'b0};
    end
  end

  // Transfer length target, which may be updated at any time (even mid-transfer)
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)               counter_trgt <= TRGT_RST;
    else if (counter_in_upd) counter_trgt <= en_quad_in ? (counter_in >> 2) : counter_in;
  end

endmodule
